// File: rtl/arm_pipe_pkg.sv
// Shared encodings for the ARM-subset pipeline: ALU opcodes, shifter types,
// NZCV bit positions and forwarding-select codes.
package arm_pipe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE -> EXE bundle plus the EXE outputs. Forwarding operands exist only
// when FORWARDING_EN is defined.
interface exe_stage_if #(parameter int WIDTH = 32);
  logic             wb_en_in, mem_read_en_in, mem_write_en_in;
  logic             B_in, S_in;
  logic [3:0]       exe_cmd_in;
  logic [WIDTH-1:0] PC_in, val_Rn_in, val_Rm_in;
  logic [11:0]      shift_operand_in;
  logic             imm_in;
  logic [23:0]      signed_imm_24_in;
  logic [3:0]       dest_in;
  logic [3:0]       status_register_id;
`ifdef FORWARDING_EN
  logic [1:0]       sel_src1, sel_src2;
  logic [WIDTH-1:0] mem_alu_result, wb_value;
`endif
  logic [WIDTH-1:0] alu_result, branch_address, val_Rm;
  logic             branch_taken;
  logic [3:0]       status_register;
  logic             wb_en, mem_read_en, mem_write_en;
  logic [3:0]       dest;

  modport master (
`ifdef FORWARDING_EN
    output sel_src1, sel_src2, mem_alu_result, wb_value,
`endif
    output wb_en_in, mem_read_en_in, mem_write_en_in, B_in, S_in, exe_cmd_in,
           PC_in, val_Rn_in, val_Rm_in, shift_operand_in, imm_in,
           signed_imm_24_in, dest_in, status_register_id,
    input  alu_result, branch_address, branch_taken, status_register,
           wb_en, mem_read_en, mem_write_en, val_Rm, dest
  );

  modport slave (
`ifdef FORWARDING_EN
    input  sel_src1, sel_src2, mem_alu_result, wb_value,
`endif
    input  wb_en_in, mem_read_en_in, mem_write_en_in, B_in, S_in, exe_cmd_in,
           PC_in, val_Rn_in, val_Rm_in, shift_operand_in, imm_in,
           signed_imm_24_in, dest_in, status_register_id,
    output alu_result, branch_address, branch_taken, status_register,
           wb_en, mem_read_en, mem_write_en, val_Rm, dest
  );
endinterface

// File: rtl/val2_gen.sv
// Operand-2 generator: memory offset, rotated immediate or shifted Rm.
// Purely combinational.
module val2_gen
  import arm_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_rm_i,
  input  logic [11:0]      shift_operand_i,
  input  logic             imm_i,
  input  logic             mem_en_i,
  output logic [WIDTH-1:0] val2_o
);

  logic [WIDTH-1:0]   imm_ext;
  logic [4:0]         rot_amt, sh_amt;
  logic [2*WIDTH-1:0] imm_dbl, rm_dbl;
  logic [WIDTH-1:0]   rm_shifted;

  assign imm_ext = WIDTH'(shift_operand_i[7:0]);
  assign rot_amt = {shift_operand_i[11:8], 1'b0};
  assign sh_amt  = shift_operand_i[11:7];
  // Rotations via a doubled vector: the low half of ({x,x} >> n) is ror(x, n).
  assign imm_dbl = {imm_ext, imm_ext} >> rot_amt;
  assign rm_dbl  = {val_rm_i, val_rm_i} >> sh_amt;

  always_comb begin
    rm_shifted = val_rm_i;
    case (shift_t'(shift_operand_i[6:5]))
      SH_LSL: rm_shifted = val_rm_i << sh_amt;
      SH_LSR: rm_shifted = val_rm_i >> sh_amt;
      SH_ASR: rm_shifted = WIDTH'($signed(val_rm_i) >>> sh_amt);
      SH_ROR: rm_shifted = rm_dbl[WIDTH-1:0];
      default: rm_shifted = val_rm_i;
    endcase
  end

  always_comb begin
    if (mem_en_i)   val2_o = WIDTH'(shift_operand_i);
    else if (imm_i) val2_o = imm_dbl[WIDTH-1:0];
    else            val2_o = rm_shifted;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand 2, ALU, branch target and the NZCV status register.
// Define FORWARDING_EN to select Rn/Rm from the MEM and WB bypass values.
module exe_stage
  import arm_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] src1, src2, val2, res;
  logic [WIDTH:0]   add_sum, sub_sum;
  logic             cin, n_f, z_f, c_f, v_f;
  logic [3:0]       status_q, status_d;

`ifdef FORWARDING_EN
  always_comb begin
    case (bus.sel_src1)
      FWD_MEM: src1 = bus.mem_alu_result;
      FWD_WB:  src1 = bus.wb_value;
      default: src1 = bus.val_Rn_in;
    endcase
    case (bus.sel_src2)
      FWD_MEM: src2 = bus.mem_alu_result;
      FWD_WB:  src2 = bus.wb_value;
      default: src2 = bus.val_Rm_in;
    endcase
  end
`else
  assign src1 = bus.val_Rn_in;
  assign src2 = bus.val_Rm_in;
`endif

  val2_gen #(.WIDTH(WIDTH)) u_val2 (
    .val_rm_i        (src2),
    .shift_operand_i (bus.shift_operand_in),
    .imm_i           (bus.imm_in),
    .mem_en_i        (bus.mem_read_en_in | bus.mem_write_en_in),
    .val2_o          (val2)
  );

  // Carry-in comes from the ID-stage snapshot so it matches the condition check.
  assign cin = bus.status_register_id[FLAG_C];
  // Subtract as Rn + ~val2 + 1 (SUB) or + C (SBC); carry-out is then NOT borrow.
  assign add_sum = {1'b0, src1} + {1'b0, val2}
                 + (WIDTH+1)'(bus.exe_cmd_in == CMD_ADC ? cin : 1'b0);
  assign sub_sum = {1'b0, src1} + {1'b0, ~val2}
                 + (WIDTH+1)'(bus.exe_cmd_in == CMD_SUB ? 1'b1 : cin);

  always_comb begin
    res = '0;
    c_f = bus.status_register_id[FLAG_C];
    v_f = bus.status_register_id[FLAG_V];
    case (bus.exe_cmd_in)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = src1 & val2;
      CMD_ORR: res = src1 | val2;
      CMD_EOR: res = src1 ^ val2;
      CMD_ADD, CMD_ADC: begin
        res = add_sum[MSB:0];
        c_f = add_sum[WIDTH];
        v_f = (src1[MSB] == val2[MSB]) && (res[MSB] != src1[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        res = sub_sum[MSB:0];
        c_f = sub_sum[WIDTH];
        v_f = (src1[MSB] != val2[MSB]) && (res[MSB] != src1[MSB]);
      end
      default: begin
        res = '0;
        c_f = status_q[FLAG_C];
        v_f = status_q[FLAG_V];
      end
    endcase
  end

  assign n_f = res[MSB];
  assign z_f = (res == '0);

  always_comb begin
    status_d         = status_q;
    status_d[FLAG_N] = n_f;
    status_d[FLAG_Z] = z_f;
    status_d[FLAG_C] = c_f;
    status_d[FLAG_V] = v_f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             status_q <= 4'b0000;
    else if (bus.S_in)   status_q <= status_d;
  end

  assign bus.alu_result      = res;
  assign bus.branch_address  = bus.PC_in
                             + {{(WIDTH-26){bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};
  assign bus.branch_taken    = bus.B_in;
  assign bus.status_register = status_q;
  assign bus.wb_en           = bus.wb_en_in;
  assign bus.mem_read_en     = bus.mem_read_en_in;
  assign bus.mem_write_en    = bus.mem_write_en_in;
  assign bus.val_Rm          = src2;
  assign bus.dest            = bus.dest_in;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_exe_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exe_stage_if #(.WIDTH(32)) bus ();

  exe_stage #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  cmd;
    logic        s, b, imm;
    logic [2:0]  mem;      // {wb, mem_read, mem_write}
    logic [31:0] pc, rn, rm;
    logic [11:0] so;
    logic [23:0] imm24;
    logic [3:0]  dest, sid;
    logic [31:0] e_alu, e_ba;
    logic [3:0]  e_st;     // status visible during this vector's cycle
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] alu, ba, rm;
    logic        bt;
    logic [3:0]  st;
    logic [6:0]  ctl;
  } exp_t;

  localparam int NV = 17;
  vec_t v [NV];
  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic r, logic [3:0] c, logic s, logic b, logic im,
                              logic [2:0] m, logic [31:0] pc, logic [31:0] rn,
                              logic [31:0] rm, logic [11:0] so, logic [23:0] i24,
                              logic [3:0] d, logic [3:0] sid, logic [31:0] ea,
                              logic [31:0] eb, logic [3:0] es);
    vec_t t;
    t.rst = r; t.cmd = c; t.s = s; t.b = b; t.imm = im; t.mem = m;
    t.pc = pc; t.rn = rn; t.rm = rm; t.so = so; t.imm24 = i24;
    t.dest = d; t.sid = sid; t.e_alu = ea; t.e_ba = eb; t.e_st = es;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, want);
    end
  endtask

  initial begin
    //          rst cmd  S  B  imm mem     PC            Rn            Rm            so      imm24      dst   sid      alu           br_addr       st
    v[0]  = mk(1, 4'h1, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        12'h000, 24'h0,      4'h0, 4'b0000, 32'h0,        32'h0,        4'b0000);
    v[1]  = mk(0, 4'h2, 1, 0, 1, 3'b100, 32'h100,      32'h7FFFFFFF, 32'h0,        12'h001, 24'h000001, 4'h3, 4'b0000, 32'h80000000, 32'h104,      4'b0000);
    v[2]  = mk(0, 4'h1, 0, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        12'h4FF, 24'h0,      4'h0, 4'b0000, 32'hFF000000, 32'h0,        4'b1001);
    v[3]  = mk(0, 4'h4, 1, 0, 1, 3'b000, 32'h0,        32'h5,        32'h0,        12'h005, 24'h0,      4'h0, 4'b0000, 32'h0,        32'h0,        4'b1001);
    v[4]  = mk(0, 4'h7, 1, 0, 0, 3'b000, 32'h0,        32'h0F0,      32'h80000000, 12'h240, 24'h0,      4'h0, 4'b0001, 32'hF80000F0, 32'h0,        4'b0110);
    v[5]  = mk(0, 4'h3, 1, 0, 0, 3'b000, 32'h0,        32'hFFFFFFFF, 32'h0,        12'h000, 24'h0,      4'h0, 4'b0010, 32'h0,        32'h0,        4'b1001);
    v[6]  = mk(0, 4'h1, 0, 1, 1, 3'b000, 32'h10,       32'h0,        32'h0,        12'h000, 24'hFFFFFE, 4'h0, 4'b0000, 32'h0,        32'h8,        4'b0110);
    v[7]  = mk(0, 4'h2, 0, 0, 1, 3'b110, 32'h0,        32'h1000,     32'hDEADBEEF, 12'hFFF, 24'h0,      4'hA, 4'b0000, 32'h1FFF,     32'h0,        4'b0110);
    v[8]  = mk(0, 4'h5, 1, 0, 1, 3'b000, 32'h0,        32'h5,        32'h0,        12'h003, 24'h0,      4'h0, 4'b0000, 32'h1,        32'h0,        4'b0110);
    v[9]  = mk(0, 4'h8, 0, 0, 0, 3'b000, 32'hFFFFFFFC, 32'hFF00FF00, 32'h12345678, 12'h460, 24'h000002, 4'h5, 4'b0000, 32'h8712CB56, 32'h4,        4'b0010);
    v[10] = mk(0, 4'h6, 0, 0, 0, 3'b000, 32'h0,        32'hFFFFFFFF, 32'h80000000, 12'hFA0, 24'h0,      4'h0, 4'b0000, 32'h1,        32'h0,        4'b0010);
    v[11] = mk(0, 4'h9, 1, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        12'h000, 24'h0,      4'h0, 4'b0011, 32'hFFFFFFFF, 32'h0,        4'b0010);
    v[12] = mk(0, 4'h0, 1, 0, 1, 3'b000, 32'h0,        32'h1234,     32'h0,        12'h000, 24'h0,      4'h0, 4'b0000, 32'h0,        32'h0,        4'b1011);
    v[13] = mk(0, 4'h4, 1, 0, 0, 3'b000, 32'h0,        32'h1,        32'h1,        12'hF80, 24'h0,      4'h0, 4'b0000, 32'h80000001, 32'h0,        4'b0111);
    v[14] = mk(1, 4'h2, 1, 0, 1, 3'b000, 32'h0,        32'hFFFFFFFF, 32'h0,        12'h001, 24'h0,      4'h0, 4'b0000, 32'h0,        32'h0,        4'b0000);
    v[15] = mk(0, 4'h1, 0, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        12'h005, 24'h0,      4'h0, 4'b0000, 32'h5,        32'h0,        4'b0000);
    v[16] = mk(0, 4'h1, 0, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        12'h000, 24'h0,      4'h0, 4'b0000, 32'h0,        32'h0,        4'b0000);
  end

  // Stimulus: apply one vector per cycle just after the rising edge.
  initial begin
    exp_t e;
`ifdef FORWARDING_EN
    bus.sel_src1 = 2'b00; bus.sel_src2 = 2'b00;
    bus.mem_alu_result = 32'h0; bus.wb_value = 32'h0;
`endif
    bus.wb_en_in = 0; bus.mem_read_en_in = 0; bus.mem_write_en_in = 0;
    bus.B_in = 0; bus.S_in = 0; bus.exe_cmd_in = 4'h0; bus.PC_in = 32'h0;
    bus.val_Rn_in = 32'h0; bus.val_Rm_in = 32'h0; bus.shift_operand_in = 12'h0;
    bus.imm_in = 0; bus.signed_imm_24_in = 24'h0; bus.dest_in = 4'h0;
    bus.status_register_id = 4'h0;
    #2 rst = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      rst                    = v[i].rst;
      bus.exe_cmd_in         = v[i].cmd;
      bus.S_in               = v[i].s;
      bus.B_in               = v[i].b;
      bus.imm_in             = v[i].imm;
      {bus.wb_en_in, bus.mem_read_en_in, bus.mem_write_en_in} = v[i].mem;
      bus.PC_in              = v[i].pc;
      bus.val_Rn_in          = v[i].rn;
      bus.val_Rm_in          = v[i].rm;
      bus.shift_operand_in   = v[i].so;
      bus.signed_imm_24_in   = v[i].imm24;
      bus.dest_in            = v[i].dest;
      bus.status_register_id = v[i].sid;
      e.idx = i; e.alu = v[i].e_alu; e.ba = v[i].e_ba; e.rm = v[i].rm;
      e.bt  = v[i].b; e.st = v[i].e_st; e.ctl = {v[i].mem, v[i].dest};
      exp_q.push_back(e);
    end
    bus.S_in = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Monitor: outputs are settled mid-cycle, compare at the falling edge.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        chk("alu_result",      m.idx, bus.alu_result,     m.alu);
        chk("branch_address",  m.idx, bus.branch_address, m.ba);
        chk("branch_taken",    m.idx, 32'(bus.branch_taken), 32'(m.bt));
        chk("status_register", m.idx, 32'(bus.status_register), 32'(m.st));
        chk("val_Rm",          m.idx, bus.val_Rm,         m.rm);
        chk("ctl_passthru",    m.idx,
            32'({bus.wb_en, bus.mem_read_en, bus.mem_write_en, bus.dest}), 32'(m.ctl));
      end
    end
  end

  initial begin
    #5000;
    $display("FAIL timeout: got no finish expected finish by 5000");
    $fatal(1, "timeout");
  end

endmodule
